// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants and scanout state encoding.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/vga_pos_counter.sv
// vga_pos_counter: H/V wrap counters with enable and clear; parks at the last position when cleared.
module vga_pos_counter
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic [9:0] o_h_nxt,
  output logic [9:0] o_v_nxt
);
  logic [9:0] r_h, r_v;
  assign o_h = r_h;
  assign o_v = r_v;
  assign o_h_nxt = (r_h == H_MAX) ? 10'd0 : r_h + 10'd1;
  assign o_v_nxt = (r_h != H_MAX) ? r_v : (r_v == V_MAX) ? 10'd0 : r_v + 10'd1;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_h <= H_MAX;
      r_v <= V_MAX;
    end else if (i_clr) begin
      r_h <= H_MAX;
      r_v <= V_MAX;
    end else if (i_en) begin
      r_h <= o_h_nxt;
      r_v <= o_v_nxt;
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480 VGA timing and pixel scanout from a line FIFO.
// Optional colour-bar generator under VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             s_rst,
  input  logic             pixel_clk,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             test_mode,
  output logic [9:0]       hcount,
  output logic [9:0]       vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] rgb,
  output logic             sof,
  underflow
);
  state_t r_state, w_state_nxt;
  logic [9:0] w_hn, w_vn;
  logic w_adv, w_act_n, w_tp;
  logic [PIX_W-1:0] w_pat, w_rgb_nxt;
  logic r_hs, r_vs, r_de, r_sof, r_uf;
  logic [PIX_W-1:0] r_rgb;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic [2:0] w_bar;
  assign w_tp = test_mode;
  assign w_bar = 3'(w_hn / 10'd80);
  assign w_pat = {PIX_W{1'b1}} >> w_bar;
`else
  logic w_unused_tm;
  assign w_unused_tm = test_mode;
  assign w_tp = 1'b0;
  assign w_pat = '0;
`endif
  // IDLE only leaves on a strobe with data available; the counter's park position wraps to (0,0)
  assign w_adv = pixel_clk & ~s_rst & ((r_state == RUN) | pix_valid);
  assign w_act_n = (w_hn < H_ACT) & (w_vn < V_ACT);
  assign pix_ready = w_adv & w_act_n & pix_valid & ~w_tp;
  assign w_rgb_nxt = !w_act_n ? '0 : w_tp ? w_pat : pix_valid ? pix_data : '0;
  vga_pos_counter u_pos (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_en   (w_adv),
    .i_clr  (s_rst),
    .o_h    (hcount),
    .o_v    (vcount),
    .o_h_nxt(w_hn),
    .o_v_nxt(w_vn)
  );
  always_comb begin
    w_state_nxt = s_rst ? IDLE : w_adv ? RUN : r_state;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hs <= 1'b1; r_vs <= 1'b1; r_de <= 1'b0; r_rgb <= '0; r_sof <= 1'b0; r_uf <= 1'b0;
    end else if (s_rst) begin
      r_hs <= 1'b1; r_vs <= 1'b1; r_de <= 1'b0; r_rgb <= '0; r_sof <= 1'b0; r_uf <= 1'b0;
    end else begin
      r_sof <= w_adv & (w_hn == 10'd0) & (w_vn == 10'd0);
      r_uf <= w_adv & w_act_n & ~pix_valid & ~w_tp;
      if (w_adv) begin
        r_de <= w_act_n;
        r_hs <= !(w_hn >= H_SS && w_hn < H_SE);
        r_vs <= !(w_vn >= V_SS && w_vn < V_SE);
        r_rgb <= w_rgb_nxt;
      end
    end
  end
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign de = r_de;
  assign rgb = r_rgb;
  assign sof = r_sof;
  assign underflow = r_uf;
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel data/colour width.
REQ-002 SHALL have port clk  input  1  system clock (150 MHz).
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_rst  input  1  synchronous clear to idle, active-high.
REQ-005 SHALL have port pixel_clk  input  1  one-cycle pixel strobe from timertop; all advancement qualified by it.
REQ-006 SHALL have port pix_data  input  PIX_W  pixel from upstream line FIFO.
REQ-007 SHALL have port pix_valid  input  1  pix_data present.
REQ-008 SHALL have port pix_ready  output  1  pop; combinational.
REQ-009 SHALL have port test_mode  input  1  colour-bar select (used only under macro).
REQ-010 SHALL have port hcount  output  10  current column 0..799.
REQ-011 SHALL have port vcount  output  10  current line 0..524.
REQ-012 SHALL have port hsync, vsync  output  1 each  active-low syncs.
REQ-013 SHALL have port de  output  1  active-video flag.
REQ-014 SHALL have port rgb  output  PIX_W  pixel out, 0 when de low.
REQ-015 SHALL have port sof  output  1  one-cycle pulse on entering (0,0).
REQ-016 SHALL have port underflow  output  1  one-cycle pulse on missing active pixel.

Function
REQ-017 SHALL use 640x480 timing: H active 640, FP 16, sync 96, BP 48, total 800; V active 480, FP 10, sync 2, BP 33, total 525.
REQ-018 SHALL implement states IDLE and RUN.
REQ-019 IDLE SHALL hold hcount=799, vcount=524; on pixel_clk with pix_valid=1, go RUN and wrap to (0,0).
REQ-020 In IDLE, pixel_clk with pix_valid=0 SHALL change nothing.
REQ-021 RUN SHALL advance hcount on every pixel_clk; hcount 799->0 with vcount+1; vcount 524->0.
REQ-022 Registered outputs SHALL update on the edge ending the pixel_clk cycle, aligned to the new (hcount,vcount).
REQ-023 de SHALL be 1 iff hcount<640 and vcount<480.
REQ-024 hsync SHALL be 0 iff 656<=hcount<752; vsync SHALL be 0 iff 490<=vcount<492.
REQ-025 pix_ready SHALL be 1 only in a pixel_clk cycle whose next position is active and pix_valid=1.
REQ-026 rgb SHALL load pix_data when popped; 0 in blanking.
REQ-027 Next position active with pix_valid=0 SHALL give rgb=0, underflow=1 for one cycle, no pop, timing unaffected.
REQ-028 sof SHALL pulse one cycle on every entry into (0,0), including the IDLE->RUN transition.
REQ-029 Without pixel_clk, all registers SHALL hold.
REQ-030 s_rst SHALL take priority over pixel_clk and restore reset values.

Reset
REQ-031 n_rst low SHALL force IDLE, hcount=799, vcount=524, hsync=1, vsync=1, de=0, rgb=0, sof=0, underflow=0.
REQ-032 n_rst or s_rst mid-frame SHALL abort the frame; restart waits for pix_valid per REQ-019.

Configuration
REQ-033 Macro VGA_SCANOUT_TEST_PATTERN_EN defined: test_mode=1 SHALL drive 8 colour bars of 80 columns, rgb = {PIX_W{1'b1}} >> bar index; pix_ready held 0; underflow held 0.
REQ-034 Macro undefined: test_mode SHALL be ignored; no pattern logic synthesised.

Structure
REQ-035 Package vga_pkg SHALL hold the H/V timing localparams, derived sync start/end constants and the IDLE/RUN state enum.
REQ-036 Sub-module vga_pos_counter SHALL implement the H/V wrap counters with enable and clear.

Verification
REQ-037 Reset, 10 pixel_clk strobes with pix_valid=0 -> state IDLE, hcount=799, vcount=524, no pops.
REQ-038 pix_valid held 1, pix_data=hcount[7:0] -> first strobe: sof=1, (0,0), rgb=0x00, de=1; column 639 -> rgb=0x7F; column 640 -> de=0, rgb=0.
REQ-039 Full frame, 420000 strobes -> hsync low exactly 96 strobes per line, vsync low lines 490-491, sof every 420000 strobes.
REQ-040 pix_valid dropped at (100,5) -> rgb=0, underflow one-cycle pulse, pix_ready=0, (101,5) follows.
REQ-041 s_rst at (300,200) simultaneous with pixel_clk -> IDLE reset values next cycle, no advance.
REQ-042 Macro defined, test_mode=1 -> column 0 rgb=0xFF, column 80 rgb=0x7F, pix_ready never 1.
